// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table sequencer.
// The mismatch locator is built only when TT_SEQ_MISMATCH_LOG_EN is defined.
package tt_seq_pkg;

  localparam int NUM_COMBOS = 8;
  localparam int TT_W       = 8;
  localparam int COMBO_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Combo 0 lands in the MSB of the table, combo 7 in the LSB.
  function automatic logic [COMBO_W-1:0] bit_pos(input logic [COMBO_W-1:0] idx);
    return COMBO_W'(NUM_COMBOS - 1) - idx;
  endfunction

`ifdef TT_SEQ_MISMATCH_LOG_EN
  // Lowest combo index whose table bit is set in diff; 0 when diff is clear.
  function automatic logic [COMBO_W-1:0] first_mismatch(input logic [TT_W-1:0] diff);
    logic [COMBO_W-1:0] idx;
    idx = '0;
    for (int i = NUM_COMBOS - 1; i >= 0; i--) begin
      if (diff[bit_pos(COMBO_W'(i))]) idx = COMBO_W'(i);
    end
    return idx;
  endfunction
`endif

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that times how long each input combination is held.
// load arms it; while en is high it counts to zero and flags expire on the last hold cycle.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/tt_sequencer.sv
// Sweeps all 8 input combinations of a 3-input gate, captures its truth table and compares it.
// Defining TT_SEQ_MISMATCH_LOG_EN adds mismatch_valid/mismatch_idx reporting the first bad combo.
module tt_sequencer
  import tt_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TT_W-1:0]    expected,
  input  logic               dut_out,
  output logic [COMBO_W-1:0] dut_in,
  output logic               busy,
  output logic               done,
  output logic [TT_W-1:0]    table_out,
  output logic               match
`ifdef TT_SEQ_MISMATCH_LOG_EN
  ,
  output logic               mismatch_valid,
  output logic [COMBO_W-1:0] mismatch_idx
`endif
);

  state_e             state_q, state_d;
  logic [COMBO_W-1:0] idx_q, idx_d;
  logic [TT_W-1:0]    work_q, work_d;
  logic [TT_W-1:0]    table_q, table_d;
  logic               match_q, match_d;
  logic [TT_W-1:0]    captured;
  logic               timer_load;
  logic               timer_en;
  logic               timer_expire;

`ifdef TT_SEQ_MISMATCH_LOG_EN
  logic               mm_valid_q, mm_valid_d;
  logic [COMBO_W-1:0] mm_idx_q, mm_idx_d;
`endif

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  assign timer_en = (state_q == APPLY);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    work_d     = work_q;
    table_d    = table_q;
    match_d    = match_q;
    timer_load = 1'b0;
    captured   = work_q;
    captured[bit_pos(idx_q)] = dut_out;
`ifdef TT_SEQ_MISMATCH_LOG_EN
    mm_valid_d = mm_valid_q;
    mm_idx_d   = mm_idx_q;
`endif

    case (state_q)
      IDLE: begin
        idx_d = '0;
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_d    = APPLY;
          work_d     = '0;
          timer_load = 1'b1;
        end
      end

      APPLY: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (timer_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          work_d = captured;
          if (idx_q == COMBO_W'(NUM_COMBOS - 1)) begin
            state_d = DONE;
            idx_d   = '0;
            // Results are published only on a completed sweep.
            table_d = captured;
            match_d = (captured == expected);
`ifdef TT_SEQ_MISMATCH_LOG_EN
            mm_valid_d = |(captured ^ expected);
            mm_idx_d   = first_mismatch(captured ^ expected);
`endif
          end else begin
            state_d    = APPLY;
            idx_d      = idx_q + COMBO_W'(1);
            timer_load = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      work_q     <= '0;
      table_q    <= '0;
      match_q    <= 1'b0;
`ifdef TT_SEQ_MISMATCH_LOG_EN
      mm_valid_q <= 1'b0;
      mm_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      work_q     <= work_d;
      table_q    <= table_d;
      match_q    <= match_d;
`ifdef TT_SEQ_MISMATCH_LOG_EN
      mm_valid_q <= mm_valid_d;
      mm_idx_q   <= mm_idx_d;
`endif
    end
  end

  assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign dut_in    = busy ? idx_q : '0;
  assign table_out = table_q;
  assign match     = match_q;

`ifdef TT_SEQ_MISMATCH_LOG_EN
  assign mismatch_valid = mm_valid_q;
  assign mismatch_idx   = mm_idx_q;
`endif

endmodule

// File: doc/tt_sequencer.md
TT_SEQUENCER -- requirements
Module: tt_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, number of cycles each input combination is held before sampling (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one truth-table sweep.
REQ-005 SHALL have port abort  input  1  cancel the sweep in progress.
REQ-006 SHALL have port expected  input  8  expected truth-table code, e.g. 0xFA.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input gate under test.
REQ-008 SHALL have port dut_in  output  3  {in1,in2,in3} driven to the gate under test.
REQ-009 SHALL have port busy  output  1  high while a sweep runs.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port table_out  output  8  captured truth table.
REQ-012 SHALL have port match  output  1  table_out == expected, valid from done.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-014 IDLE: dut_in=3'b000, busy=0; start=1 at an edge -> APPLY with combo index i=0, busy=1 the next cycle.
REQ-015 APPLY: dut_in=i, held for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-016 SAMPLE (1 cycle, dut_in=i): capture dut_out into table bit [7-i]; i<7 -> APPLY with i+1; i==7 -> DONE.
REQ-017 Bit mapping: combo 3'b000 maps to table_out[7], combo 3'b111 maps to table_out[0].
REQ-018 DONE (1 cycle): done=1, busy=0, table_out and match updated; -> IDLE.
REQ-019 Latency: start sampled at edge k -> done high in cycle k+1+8*(SETTLE_CYCLES+1).
REQ-020 table_out and match SHALL hold their values from DONE until the next DONE.
REQ-021 start while not in IDLE (including DONE) SHALL be ignored.
REQ-022 abort=1 in APPLY or SAMPLE SHALL return to IDLE next cycle: no done, table_out/match unchanged.
REQ-023 Simultaneous start and abort in IDLE: abort wins, stay IDLE.
REQ-024 abort in IDLE or DONE SHALL have no effect (a DONE pulse still completes).

Reset
REQ-025 rst=1 SHALL force IDLE, i=0, dut_in=0, busy=0, done=0, table_out=8'h00, match=0 on the next edge, including mid-sweep.
REQ-026 rst SHALL take priority over start and abort.

Configuration
REQ-027 With TT_SEQ_MISMATCH_LOG_EN defined, SHALL add outputs mismatch_valid (1) and mismatch_idx (3): lowest combo index whose captured bit differs from expected, valid from DONE to next DONE, reset to 0.
REQ-028 Without TT_SEQ_MISMATCH_LOG_EN, those ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package tt_seq_pkg SHALL hold the state enum, NUM_COMBOS=8, TT_W=8, COMBO_W=3.
REQ-030 Settle counting SHALL be a sub-module tt_settle_timer (load, count-down, expire pulse), width sized from SETTLE_CYCLES.

Verification
REQ-031 Gate model 0xFA, expected=8'hFA, SETTLE_CYCLES=4, start at cycle 0 -> done at cycle 41, table_out=8'hFA, match=1.
REQ-032 Same gate, expected=8'hFB -> match=0; with macro, mismatch_valid=1 and mismatch_idx=3'd7.
REQ-033 start pulsed again at cycle 10 of a sweep -> ignored; done still at cycle 41, exactly one done pulse.
REQ-034 abort during APPLY with i=3 -> IDLE next cycle, dut_in=0, no done, table_out keeps previous value.
REQ-035 rst during SAMPLE with i=5 -> next cycle all outputs at reset values; new start runs a full 41-cycle sweep.
REQ-036 Gate stuck at 1, expected=8'hFF, SETTLE_CYCLES=1 -> done at cycle 17, table_out=8'hFF, match=1.
